duty_reporter: RTL and testbench

- UART-TX-side companion to the duty-cycle command parser.
- Samples the current 7-bit PWM duty cycle and emits a fixed 8-byte ASCII status line to the UART transmitter: prefix, '=', three decimal digits, '%', CR, LF.
- Decimal conversion is sequential (repeated subtraction).
- Output bytes use a valid/ready handshake into the UART TX block.

---
 rtl/duty_reporter.sv | 151 +++++++++++++++
 tb/tb_duty_reporter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/duty_reporter.sv
// duty_reporter
//   Samples the 7-bit PWM duty cycle and sends an ASCII status line to the
//   UART transmitter: PREFIX '=' H T U '%' [CR LF].
//   The decimal digits come from repeated subtraction, one step per clock.
//   Bytes leave on a valid/ready handshake.
//
// Parameters
//   PREFIX_CHAR  first byte of every message (default 'D')
//   SEND_CRLF    1: append CR LF (8 bytes), 0: no CR LF (6 bytes)
//
// Optional feature (define DUTY_REPORTER_AUTO_EN)
//   When a new duty_cycle value differs from the last sampled value, the
//   block requests a report on its own. Every settled change of duty_cycle
//   produces exactly one report of its final value.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   duty_cycle  current duty cycle, 0-127
//   report_req  single-cycle request for a status line
//   tx_ready    UART TX accepts a byte this cycle
//   tx_data     ASCII byte to transmit
//   tx_valid    tx_data valid; a byte transfers on an edge with tx_valid && tx_ready
//   busy        high while a report is converting or sending
module duty_reporter #(
  parameter logic [7:0] PREFIX_CHAR = 8'h44,
  parameter bit         SEND_CRLF   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] duty_cycle,
  input  logic       report_req,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;

  // Index of the final byte: LF, or '%' when CR LF is left off.
  localparam logic [2:0] LAST_IDX = SEND_CRLF ? 3'd7 : 3'd5;

  logic [1:0] state;
  logic [6:0] rem;
  logic       hund;
  logic [3:0] tens;
  logic [3:0] units;
  logic [2:0] idx;
  logic       pending;

  logic [2:0] idx_nxt;
  logic [7:0] nxt_byte;
  logic       start_req;

`ifdef DUTY_REPORTER_AUTO_EN
  // Holds the value that was last converted. A mismatch counts as a request.
  logic [6:0] last_duty;
  assign start_req = report_req | (duty_cycle != last_duty);
`else
  assign start_req = report_req;
`endif

  assign busy    = (state != S_IDLE);
  assign idx_nxt = idx + 3'd1;

  // Byte that follows the current index in the message.
  always_comb begin
    nxt_byte = PREFIX_CHAR;
    case (idx_nxt)
      3'd1:    nxt_byte = 8'h3D;
      3'd2:    nxt_byte = 8'h30 + {7'd0, hund};
      3'd3:    nxt_byte = 8'h30 + {4'd0, tens};
      3'd4:    nxt_byte = 8'h30 + {4'd0, units};
      3'd5:    nxt_byte = 8'h25;
      3'd6:    nxt_byte = 8'h0D;
      3'd7:    nxt_byte = 8'h0A;
      default: nxt_byte = PREFIX_CHAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rem      <= 7'd0;
      hund     <= 1'b0;
      tens     <= 4'd0;
      units    <= 4'd0;
      idx      <= 3'd0;
      pending  <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
`ifdef DUTY_REPORTER_AUTO_EN
      last_duty <= 7'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_req || pending) begin
            rem     <= duty_cycle;
            hund    <= 1'b0;
            tens    <= 4'd0;
            pending <= 1'b0;
            state   <= S_CONVERT;
`ifdef DUTY_REPORTER_AUTO_EN
            last_duty <= duty_cycle;
`endif
          end
        end

        S_CONVERT: begin
          // Requests that arrive while busy collapse into a single pending one.
          if (start_req) pending <= 1'b1;
          if (rem >= 7'd100) begin
            rem  <= rem - 7'd100;
            hund <= hund + 1'b1;
          end else if (rem >= 7'd10) begin
            rem  <= rem - 7'd10;
            tens <= tens + 4'd1;
          end else begin
            // rem < 10 here, so the low nibble is the whole units digit.
            units    <= rem[3:0];
            idx      <= 3'd0;
            tx_data  <= PREFIX_CHAR;
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end
        end

        S_SEND: begin
          // A request on the same edge as the final transfer is still kept.
          if (start_req) pending <= 1'b1;
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end else begin
              idx     <= idx_nxt;
              tx_data <= nxt_byte;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duty_reporter.sv
module tb_duty_reporter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] duty_cycle = 7'd0;
  logic       report_req = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data, tx_data6;
  logic       tx_valid, tx_valid6, busy, busy6;

  always #5 clk = ~clk;

  duty_reporter dut (
    .clk(clk), .rst(rst), .duty_cycle(duty_cycle), .report_req(report_req),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy)
  );

  duty_reporter #(.PREFIX_CHAR(8'h44), .SEND_CRLF(1'b0)) dut6 (
    .clk(clk), .rst(rst), .duty_cycle(duty_cycle), .report_req(report_req),
    .tx_ready(tx_ready), .tx_data(tx_data6), .tx_valid(tx_valid6), .busy(busy6)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         rnd_ready = 1'b0;
  logic [7:0] rx_q[$], rx6_q[$], exp_q[$], exp6_q[$];
  logic       stall_prev = 1'b0, stall6_prev = 1'b0;
  logic [7:0] data_prev = 8'h00, data6_prev = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Capture each transferred byte, and require that a stalled byte holds.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, data_prev);
      end
      if (stall6_prev) begin
        chk("hold_valid6", tx_valid6, 1);
        chk("hold_data6", tx_data6, data6_prev);
      end
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (tx_valid6 && tx_ready) rx6_q.push_back(tx_data6);
    end
    stall_prev  = !rst && tx_valid && !tx_ready;
    stall6_prev = !rst && tx_valid6 && !tx_ready;
    data_prev   = tx_data;
    data6_prev  = tx_data6;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clr();
    rx_q.delete(); rx6_q.delete(); exp_q.delete(); exp6_q.delete();
  endtask

  // Reference message, built from the decimal digits of v.
  task automatic add_exp(input int v);
    logic [7:0] b[8];
    b[0] = 8'h44; b[1] = 8'h3D;
    b[2] = 8'(48 + v / 100);
    b[3] = 8'(48 + (v / 10) % 10);
    b[4] = 8'(48 + v % 10);
    b[5] = 8'h25; b[6] = 8'h0D; b[7] = 8'h0A;
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    for (int i = 0; i < 6; i++) exp6_q.push_back(b[i]);
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) chk(tag, rx_q[i], exp_q[i]);
    chk({tag, "6_len"}, rx6_q.size(), exp6_q.size());
    for (int i = 0; i < rx6_q.size() && i < exp6_q.size(); i++) chk({tag, "6"}, rx6_q[i], exp6_q[i]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || busy6) && n < budget) begin step(); n++; end
    chk("idle_timeout", {31'd0, busy | busy6}, 0);
  endtask

  task automatic run_msg(input int v, input bit rr);
    int lat = 0;
    clr();
    add_exp(v);
    rnd_ready  = rr;
    duty_cycle = 7'(v);
    report_req = 1'b1;
    step();
    report_req = 1'b0;
    while (!tx_valid && lat < 300) begin step(); lat++; end
    chk("latency", lat, v / 100 + (v % 100) / 10 + 1);
    wait_idle(300);
    rnd_ready = 1'b0;
    tx_ready  = 1'b1;
    step();
    cmp_q("msg");
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) step();
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy6", busy6, 0);
    rst = 1'b0;
    step();

    // Directed values, including the boundaries
    run_msg(70, 1'b0);
    run_msg(0, 1'b0);
    run_msg(100, 1'b0);
    run_msg(42, 1'b1);
    run_msg(127, 1'b0);
    run_msg(5, 1'b1);
    run_msg(99, 1'b0);

    // Random values under random backpressure
    for (int k = 0; k < 12; k++) run_msg(int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));

    // Requests during SEND collapse into one follow-up report
    clr();
    add_exp(10);
    add_exp(90);
    duty_cycle = 7'd10;
    report_req = 1'b1;
    step();
    report_req = 1'b0;
    n = 0;
    while (!tx_valid && n < 300) begin step(); n++; end
    report_req = 1'b1; duty_cycle = 7'd90; step();
    report_req = 1'b0; step();
    report_req = 1'b1; step();
    report_req = 1'b0; step();
    report_req = 1'b1; step();
    report_req = 1'b0;
    repeat (80) step();
    cmp_q("pend");
    chk("pend_busy", busy, 0);

    // Reset after the third byte aborts the message
    clr();
    duty_cycle = 7'd33;
    report_req = 1'b1;
    step();
    report_req = 1'b0;
    n = 0;
    while (rx_q.size() < 3 && n < 300) begin step(); n++; end
    rst = 1'b1;
    #1;
    chk("abort_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid6", tx_valid6, 0);
    chk("abort_busy6", busy6, 0);
    chk("abort_bytes", rx_q.size(), 3);
    duty_cycle = 7'd0;
    step(); step();
    rst = 1'b0;
    step();
    run_msg(33, 1'b0);

    // Change of duty_cycle with no request
    run_msg(0, 1'b0);
    clr();
`ifdef DUTY_REPORTER_AUTO_EN
    add_exp(50);
`endif
    duty_cycle = 7'd50;
    repeat (60) step();
    cmp_q("auto");
    clr();
    repeat (40) step();
    cmp_q("hold50");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
